// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- program-counter unit for the MIPS single-cycle core.
//
// The unit holds the PC and computes the next PC itself. Next-PC sources, from
// highest to lowest priority:
//   reset, exception, (stall hold), eret, jump-register, jump, branch, PC+4.
//
// It also captures the exception PC (EPC) and traps misaligned jump-register
// targets as an address error. It can optionally include a circular
// return-address stack (RAS).
//
// Optional feature macro: PC_RAS_EN
//   defined   -> RAS of RAS_DEPTH x WIDTH entries; call/ret are honoured.
//   undefined -> call/ret are ignored, ras_empty=1, ras_full=0 and no
//                storage is built. The port list is identical in both builds.
//
// Parameters
//   WIDTH        PC/address width (>= 32)
//   RESET_VECTOR PC loaded on reset (zero-extended to WIDTH)
//   EXC_VECTOR   PC loaded on exception / address error (zero-extended)
//   RAS_DEPTH    return-address-stack entries, 2..16 (PC_RAS_EN only)
//
// Ports
//   clk           in   rising-edge clock
//   reset_n       in   synchronous reset, active low
//   stall         in   hold PC/EPC/RAS; exceptions are still taken
//   branch_taken  in   take conditional branch
//   branch_offset in   sign-extended word offset
//   jump          in   absolute jump (j/jal)
//   jump_target   in   26-bit instruction index
//   jump_reg      in   register jump (jr/jalr)
//   reg_target    in   register value for jump_reg
//   call          in   push return address (with jump or jump_reg)
//   ret           in   pop return address (with jump_reg)
//   exception     in   take exception
//   eret          in   return from exception
//   pc_out        out  current PC (registered)
//   pc_plus4      out  pc_out + 4 (combinational)
//   epc_out       out  exception PC (registered)
//   addr_err      out  one-cycle pulse after a trapped misaligned jr target
//   ras_empty     out  RAS holds no entries
//   ras_full      out  RAS holds RAS_DEPTH entries
// -----------------------------------------------------------------------------
module pc_unit #(
    parameter int unsigned WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
    parameter int unsigned RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump,
    input  logic [25:0]      jump_target,
    input  logic             jump_reg,
    input  logic [WIDTH-1:0] reg_target,
    input  logic             call,
    input  logic             ret,
    input  logic             exception,
    input  logic             eret,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] epc_out,
    output logic             addr_err,
    output logic             ras_empty,
    output logic             ras_full
);

    // Vectors are zero-extended to the configured address width.
    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);
    localparam logic [WIDTH-1:0] FOUR   = WIDTH'(4);

    // -------------------------------------------------------------------------
    // Architectural state
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] pc_q,  pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             addr_err_q, addr_err_d;

    // RAS request decode produced by the next-PC logic
    logic             ras_push;   // push pc_plus4
    logic             ras_pop;    // pop the top entry (used as the target)
    logic             ras_hit;    // ret with jump_reg and a non-empty RAS
    logic [WIDTH-1:0] ras_top;    // current top-of-stack value

    // -------------------------------------------------------------------------
    // Address arithmetic (all modulo 2^WIDTH; carries simply drop off)
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] jump_pc;
    logic [WIDTH-1:0] branch_pc;
    logic             reg_misaligned;

    assign seq_pc    = pc_q + FOUR;
    // Jump keeps the upper segment bits of the delay-slot address.
    assign jump_pc   = {seq_pc[WIDTH-1:28], jump_target, 2'b00};
    // Bits shifted out of the top of the offset are intentionally lost.
    assign branch_pc = seq_pc + (branch_offset << 2);
    assign reg_misaligned = (reg_target[1:0] != 2'b00);

    // -------------------------------------------------------------------------
    // Next-PC selection
    // -------------------------------------------------------------------------
    always_comb begin
        pc_d       = seq_pc;
        epc_d      = epc_q;
        addr_err_d = 1'b0;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;

        if (exception) begin
            // Exceptions override a stall: the stalled instruction is the
            // one that faulted, so its PC is what EPC must record.
            pc_d  = EXC_PC;
            epc_d = pc_q;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (eret) begin
            pc_d = epc_q;
        end else if (jump_reg) begin
            if (ras_hit) begin
                // Predicted return address replaces reg_target entirely,
                // so no alignment check applies.
                pc_d     = ras_top;
                ras_pop  = 1'b1;
                ras_push = call;
            end else if (reg_misaligned) begin
                // Trapped: treated like an exception, so no RAS push.
                pc_d       = EXC_PC;
                epc_d      = pc_q;
                addr_err_d = 1'b1;
            end else begin
                pc_d     = reg_target;
                ras_push = call;
            end
        end else if (jump) begin
            pc_d     = jump_pc;
            ras_push = call;
        end else if (branch_taken) begin
            pc_d = branch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q       <= RST_PC;
            epc_q      <= '0;
            addr_err_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign pc_out   = pc_q;
    assign pc_plus4 = seq_pc;
    assign epc_out  = epc_q;
    assign addr_err = addr_err_q;

`ifdef PC_RAS_EN
    // -------------------------------------------------------------------------
    // Return-address stack
    //
    // top_q indexes the most recent entry. A push advances top_q and writes
    // there; once full, that slot is the oldest entry, so overflow silently
    // discards the oldest return address. Reads are combinational because the
    // popped value is needed as next PC in the same cycle.
    // -------------------------------------------------------------------------
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] top_inc, top_dec;
    logic             ras_wr_en;
    logic [PTR_W-1:0] ras_wr_idx;

    // Pointer wrap handled explicitly so non-power-of-two depths work.
    assign top_inc = (top_q == PTR_MAX) ? '0 : top_q + PTR_W'(1);
    assign top_dec = (top_q == '0) ? PTR_MAX : top_q - PTR_W'(1);

    assign ras_empty = (count_q == '0);
    assign ras_full  = (count_q == CNT_FULL);
    assign ras_hit   = ret && !ras_empty;
    assign ras_top   = ras_mem[top_q];

    always_comb begin
        top_d      = top_q;
        count_d    = count_q;
        ras_wr_en  = 1'b0;
        ras_wr_idx = top_q;
        if (ras_push && ras_pop) begin
            // Call and return together: swap the top in place.
            ras_wr_en  = 1'b1;
            ras_wr_idx = top_q;
        end else if (ras_push) begin
            ras_wr_en  = 1'b1;
            ras_wr_idx = top_inc;
            top_d      = top_inc;
            if (!ras_full) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (ras_pop) begin
            top_d   = top_dec;
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            top_q   <= '0;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    // Storage has no reset; entries are only read while count_q covers them.
    always_ff @(posedge clk) begin
        if (reset_n && ras_wr_en) begin
            ras_mem[ras_wr_idx] <= seq_pc;
        end
    end
`else
    // No RAS: call/ret have no effect and the status flags are constant.
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_hit   = 1'b0;
    assign ras_top   = '0;

    logic unused_ras;
    assign unused_ras = ^{call, ret, ras_push, ras_pop};
`endif

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit -- directed self-checking bench for pc_unit (default parameters).
// Inputs are driven 1 time unit after a rising edge; outputs are checked at
// the same point after the following edge.
// -----------------------------------------------------------------------------
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        jump_reg;
    logic [31:0] reg_target;
    logic        call;
    logic        ret;
    logic        exception;
    logic        eret;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] epc_out;
    logic        addr_err;
    logic        ras_empty;
    logic        ras_full;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_target  (jump_target),
        .jump_reg     (jump_reg),
        .reg_target   (reg_target),
        .call         (call),
        .ret          (ret),
        .exception    (exception),
        .eret         (eret),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .epc_out      (epc_out),
        .addr_err     (addr_err),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) begin
            $display("check %-16s obs=%h exp=%h ok", tag, obs, exp);
        end else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 32'h0;
        jump          = 1'b0;
        jump_target   = 26'h0;
        jump_reg      = 1'b0;
        reg_target    = 32'h0;
        call          = 1'b0;
        ret           = 1'b0;
        exception     = 1'b0;
        eret          = 1'b0;
    endtask

    // Load the PC through an aligned jump-register.
    task automatic goto(input logic [31:0] addr);
        idle();
        jump_reg   = 1'b1;
        reg_target = addr;
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset_n = 1'b0;

        // Reset held for two cycles
        tick();
        tick();
        check("rst_pc",        pc_out,           32'h0);
        check("rst_epc",       epc_out,          32'h0);
        check("rst_addr_err",  {31'h0, addr_err}, 32'h0);
        check("rst_ras_empty", {31'h0, ras_empty}, 32'h1);
        check("rst_ras_full",  {31'h0, ras_full}, 32'h0);

        // Sequential fetch
        reset_n = 1'b1;
        tick(); check("seq_4",  pc_out, 32'h4);
        tick(); check("seq_8",  pc_out, 32'h8);
        tick(); check("seq_12", pc_out, 32'hC);
        check("plus4_16", pc_plus4, 32'h10);

        // Wrap at the top of the address space
        goto(32'hFFFF_FFFC);
        check("pc_top",  pc_out, 32'hFFFF_FFFC);
        check("plus4_wrap", pc_plus4, 32'h0);
        tick(); check("wrap_0", pc_out, 32'h0);

        // Backward branch
        goto(32'h0000_0100);
        branch_taken  = 1'b1;
        branch_offset = 32'hFFFF_FFFE;
        tick(); idle();
        check("branch_back", pc_out, 32'h0000_00FC);

        // Absolute jump keeps the segment bits
        goto(32'h1000_0000);
        jump        = 1'b1;
        jump_target = 26'h0000040;
        tick();
        check("jump_abs", pc_out, 32'h1000_0100);

        // Stall holds PC even with a jump pending
        stall       = 1'b1;
        jump        = 1'b1;
        jump_target = 26'h0000123;
        tick(); check("stall_1", pc_out, 32'h1000_0100);
        tick(); check("stall_2", pc_out, 32'h1000_0100);
        tick(); check("stall_3", pc_out, 32'h1000_0100);
        idle();

        // Exception wins over stall, then eret returns
        goto(32'h0000_0040);
        stall     = 1'b1;
        exception = 1'b1;
        tick(); idle();
        check("exc_pc",  pc_out,  32'h0000_0180);
        check("exc_epc", epc_out, 32'h0000_0040);
        eret = 1'b1;
        tick(); idle();
        check("eret_pc",  pc_out,  32'h0000_0040);
        check("eret_epc", epc_out, 32'h0000_0040);

        // Misaligned jump-register trap
        goto(32'h0000_0200);
        check("ae_quiet", {31'h0, addr_err}, 32'h0);
        jump_reg   = 1'b1;
        reg_target = 32'h0000_0302;
        tick(); idle();
        check("ae_pc",    pc_out,  32'h0000_0180);
        check("ae_epc",   epc_out, 32'h0000_0200);
        check("ae_pulse", {31'h0, addr_err}, 32'h1);
        tick();
        check("ae_clear", {31'h0, addr_err}, 32'h0);
        check("ae_next",  pc_out, 32'h0000_0184);

        // Everything at once: exception wins
        exception     = 1'b1;
        eret          = 1'b1;
        jump_reg      = 1'b1;
        reg_target    = 32'h0000_0300;
        jump          = 1'b1;
        jump_target   = 26'h0000010;
        branch_taken  = 1'b1;
        branch_offset = 32'h4;
        tick(); idle();
        check("prio_exc_pc",  pc_out,  32'h0000_0180);
        check("prio_exc_epc", epc_out, 32'h0000_0184);

        // Jump beats branch
        jump          = 1'b1;
        jump_target   = 26'h0000010;
        branch_taken  = 1'b1;
        branch_offset = 32'h4;
        tick(); idle();
        check("prio_jump", pc_out, 32'h0000_0040);

        // eret beats jump_reg
        eret       = 1'b1;
        jump_reg   = 1'b1;
        reg_target = 32'h0000_0300;
        tick(); idle();
        check("prio_eret", pc_out, 32'h0000_0184);

`ifndef PC_RAS_EN
        // Without the RAS, call/ret are ignored
        call       = 1'b1;
        ret        = 1'b1;
        jump_reg   = 1'b1;
        reg_target = 32'h0000_0500;
        tick(); idle();
        check("noras_pc",    pc_out, 32'h0000_0500);
        check("noras_empty", {31'h0, ras_empty}, 32'h1);
        check("noras_full",  {31'h0, ras_full},  32'h0);
`endif

        // Reset mid-operation discards a pending trap
        jump_reg   = 1'b1;
        reg_target = 32'h0000_0702;
        reset_n    = 1'b0;
        tick(); idle();
        check("rst2_pc",  pc_out,  32'h0);
        check("rst2_epc", epc_out, 32'h0);
        check("rst2_ae",  {31'h0, addr_err}, 32'h0);
        reset_n = 1'b1;

`ifdef PC_RAS_EN
        // Five calls into a 4-deep RAS, then five returns
        goto(32'h0000_0010);
        for (int i = 2; i <= 6; i++) begin
            call       = 1'b1;
            jump_reg   = 1'b1;
            reg_target = 32'(i * 16);
            tick(); idle();
            check("ras_call_pc", pc_out, 32'(i * 16));
        end
        check("ras_full",  {31'h0, ras_full},  32'h1);
        check("ras_nempty", {31'h0, ras_empty}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            ret        = 1'b1;
            jump_reg   = 1'b1;
            reg_target = 32'h0000_0800;
            tick(); idle();
            check("ras_ret_pc", pc_out, 32'h54 - 32'(k * 16));
        end
        check("ras_empty", {31'h0, ras_empty}, 32'h1);
        ret        = 1'b1;
        jump_reg   = 1'b1;
        reg_target = 32'h0000_0900;
        tick(); idle();
        check("ras_ret_fallback", pc_out, 32'h0000_0900);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
